// File: rtl/uart_rx_cmd_if.sv
// Serial-line and command-strobe bundle between the rx pin side and the
// control unit. The slave modport is the receiver/decoder.
interface uart_rx_cmd_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic [7:0] cmd_pulse;
  logic       cmd_unknown;

  modport slave (
    input  rx,
    output rx_data, rx_done, frame_err, cmd_pulse, cmd_unknown
  );

  modport master (
    output rx,
    input  rx_data, rx_done, frame_err, cmd_pulse, cmd_unknown
  );
endinterface

// File: rtl/uart_rx_cmd.sv
// 8N1 UART receiver with 16x oversampling, followed by a registered decoder
// that maps ASCII command bytes onto one-hot, one-cycle command pulses.
module uart_rx_cmd #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned OVS      = 16
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_cmd_if.slave  bus
);

  localparam int unsigned DIV = CLK_FREQ / (BAUD * OVS);
  localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TW  = (OVS > 1) ? $clog2(OVS) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [TW-1:0] TICK_MID = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_e;

  state_e        state_q, state_d;
  logic [1:0]    sync_q;
  logic [DW-1:0] div_q, div_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_done_q, rx_done_d;
  logic          frame_err_q, frame_err_d;
  logic [7:0]    cmd_q, cmd_d;
  logic          unknown_q, unknown_d;
  logic          rx_s;
  logic          tick;

  assign rx_s = sync_q[1];

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    tick_cnt_d  = tick_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;
    tick        = 1'b0;

    // Divider is parked at zero whenever no frame is in progress.
    if (state_q == IDLE || state_q == WAIT_HIGH) begin
      div_d = '0;
    end else if (div_q == DIV_LAST) begin
      div_d = '0;
      tick  = 1'b1;
    end else begin
      div_d = div_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d    = START;
          tick_cnt_d = '0;
          bit_idx_d  = '0;
        end
      end
      START: begin
        if (tick) begin
          if (tick_cnt_q == TICK_MID) begin
            tick_cnt_d = '0;
            bit_idx_d  = '0;
            state_d    = rx_s ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tick_cnt_q == TICK_END) begin
            tick_cnt_d         = '0;
            shift_d[bit_idx_q] = rx_s;
            if (bit_idx_q == 3'd7) state_d = STOP;
            else                   bit_idx_d = bit_idx_q + 3'd1;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tick_cnt_q == TICK_END) begin
            tick_cnt_d = '0;
            if (rx_s) begin
              rx_data_d = shift_q;
              rx_done_d = 1'b1;
              state_d   = IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = WAIT_HIGH;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_d     = '0;
    unknown_d = 1'b0;
    if (rx_done_q) begin
      case (rx_data_q)
        8'h72:   cmd_d = 8'h01;
        8'h63:   cmd_d = 8'h02;
        8'h48:   cmd_d = 8'h04;
        8'h4D:   cmd_d = 8'h08;
        8'h53:   cmd_d = 8'h10;
        8'h73:   cmd_d = 8'h20;
        8'h6D:   cmd_d = 8'h40;
        8'h4C:   cmd_d = 8'h80;
        default: unknown_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '1;
      state_q     <= IDLE;
      div_q       <= '0;
      tick_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      cmd_q       <= '0;
      unknown_q   <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], bus.rx};
      state_q     <= state_d;
      div_q       <= div_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
      cmd_q       <= cmd_d;
      unknown_q   <= unknown_d;
    end
  end

  assign bus.rx_data     = rx_data_q;
  assign bus.rx_done     = rx_done_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.cmd_pulse   = cmd_q;
  assign bus.cmd_unknown = unknown_q;

endmodule

// File: tb/tb_uart_rx_cmd.sv
// Directed plus randomized frames checked against a byte-level model of the
// receiver/decoder; clock is scaled so one bit is 64 clk (DIV = 4).
module tb_uart_rx_cmd;

  localparam int unsigned CLKF = 614_400;
  localparam int unsigned BIT  = 64;
  localparam logic [7:0] CMDS [8] = '{8'h72, 8'h63, 8'h48, 8'h4D, 8'h53, 8'h73, 8'h6D, 8'h4C};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_cmd_if bus ();

  uart_rx_cmd #(.CLK_FREQ(CLKF), .BAUD(9600), .OVS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int compared = 0;
  int mismatched = 0;

  // Observed event log, filled at negedge.
  int         cyc = 0;
  int         last_done_cyc = -100;
  logic [7:0] obs_done[$];
  logic [8:0] obs_cmd[$];
  int         obs_fe = 0;
  int         multi_cnt = 0;
  int         lat_bad = 0;

  // Expected event log built by the model.
  logic [7:0] exp_done[$];
  logic [8:0] exp_cmd[$];
  int         exp_fe = 0;
  logic [7:0] exp_data = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if ($countones({bus.cmd_pulse, bus.cmd_unknown}) > 1) multi_cnt++;
    if (bus.cmd_unknown || (bus.cmd_pulse != 8'h00)) begin
      obs_cmd.push_back({bus.cmd_unknown, bus.cmd_pulse});
      if (cyc != last_done_cyc + 1) lat_bad++;
    end
    if (bus.rx_done) begin
      obs_done.push_back(bus.rx_data);
      last_done_cyc = cyc;
    end
    if (bus.frame_err) obs_fe++;
  end

  function automatic logic [8:0] model_cmd(input logic [7:0] b);
    for (int i = 0; i < 8; i++)
      if (b == CMDS[i]) return {1'b0, 8'(1 << i)};
    return 9'h100;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int unsigned n);
    bus.rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    if (stop) begin
      exp_done.push_back(b);
      exp_cmd.push_back(model_cmd(b));
      exp_data = b;
    end else begin
      exp_fe++;
    end
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(b[i], BIT);
    hold(stop, BIT);
  endtask

  task automatic check_all(input string tag);
    int n;
    @(posedge clk); #1;
    chk({tag, "_done_cnt"}, obs_done.size(), exp_done.size());
    chk({tag, "_cmd_cnt"}, obs_cmd.size(), exp_cmd.size());
    n = (obs_done.size() < exp_done.size()) ? obs_done.size() : exp_done.size();
    for (int i = 0; i < n; i++) chk({tag, "_rx_data_evt"}, obs_done[i], exp_done[i]);
    n = (obs_cmd.size() < exp_cmd.size()) ? obs_cmd.size() : exp_cmd.size();
    for (int i = 0; i < n; i++) chk({tag, "_cmd_evt"}, obs_cmd[i], exp_cmd[i]);
    chk({tag, "_frame_err_cnt"}, obs_fe, exp_fe);
    chk({tag, "_onehot"}, multi_cnt, 0);
    chk({tag, "_cmd_latency"}, lat_bad, 0);
    chk({tag, "_rx_data_hold"}, bus.rx_data, exp_data);
    obs_done.delete(); obs_cmd.delete(); obs_fe = 0;
    exp_done.delete(); exp_cmd.delete(); exp_fe = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rx_data"}, bus.rx_data, 8'h00);
    chk({tag, "_rx_done"}, bus.rx_done, 1'b0);
    chk({tag, "_frame_err"}, bus.frame_err, 1'b0);
    chk({tag, "_cmd_pulse"}, bus.cmd_pulse, 8'h00);
    chk({tag, "_cmd_unknown"}, bus.cmd_unknown, 1'b0);
  endtask

  initial begin
    logic [7:0] seq [11];
    logic [7:0] s_byte;
    logic [7:0] b;
    logic       stop;
    int         k;

    bus.rx = 1'b1;
    rst    = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("reset");
    @(negedge clk);

    send(8'h72, 1'b1);
    hold(1'b1, 2 * BIT);
    check_all("r_frame");

    seq = '{8'h72, 8'h63, 8'h48, 8'h4D, 8'h53, 8'h73, 8'h73, 8'h6D, 8'h6D, 8'h4C, 8'h4C};
    foreach (seq[i]) send(seq[i], 1'b1);
    hold(1'b1, 2 * BIT);
    check_all("back_to_back");

    // Low for 3 ticks only: start bit rejected at mid-bit.
    hold(1'b0, 12);
    hold(1'b1, 2 * BIT);
    check_all("glitch");
    send(8'h63, 1'b1);
    hold(1'b1, 2 * BIT);
    check_all("after_glitch");

    send(8'h48, 1'b0);
    hold(1'b0, 3 * BIT);
    hold(1'b1, 2 * BIT);
    check_all("frame_err");
    send(8'h4D, 1'b1);
    hold(1'b1, 2 * BIT);
    check_all("after_ferr");

    send(8'h78, 1'b1);
    hold(1'b1, 2 * BIT);
    check_all("unknown");

    s_byte = 8'h53;
    hold(1'b0, BIT);
    for (int i = 0; i < 4; i++) hold(s_byte[i], BIT);
    rst    = 1'b1;
    bus.rx = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    exp_data = 8'h00;
    hold(1'b1, 2 * BIT);
    check_all("rst_abort");
    send(8'h4C, 1'b1);
    hold(1'b1, 2 * BIT);
    check_all("after_rst");

    for (int f = 0; f < 16; f++) begin
      if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, 7);
        b = CMDS[k];
      end else begin
        b = 8'($urandom);
      end
      stop = ($urandom_range(0, 5) != 0);
      send(b, stop);
      if (!stop) begin
        hold(1'b0, $urandom_range(0, 2) * BIT);
        hold(1'b1, BIT + $urandom_range(0, BIT));
      end else begin
        hold(1'b1, $urandom_range(0, 2) * BIT + $urandom_range(0, BIT - 1));
      end
    end
    hold(1'b1, 2 * BIT);
    check_all("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
